// File: rtl/spi_master_sched.sv
// Two-requester SPI command scheduler: round-robin grant, 10-bit command frame,
// optional turnaround plus 8-bit read capture. All outputs come straight from flops.
module spi_master_sched #(
   parameter int RD_TURN = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [1:0] req0_op,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [1:0] req1_op,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       rsp_valid,
   output logic       rsp_id,
   output logic [7:0] rsp_data,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO,
   output logic       busy
);

   // Handshake: a command is taken on the clock edge where IDLE sees reqN_valid and wins
   // arbitration; reqN_ready is high for exactly the following cycle to report that acceptance,
   // and the requester may change valid/op/data from then on without affecting the frame.
   typedef enum logic [2:0] {IDLE, SEL, CMD, SHIFT, END, TURN, RDCAP, DONE} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic [9:0]  frame, frame_nx;
   logic [7:0]  cap, cap_nx;
   logic        id, id_nx;
   logic        ptr, ptr_nx;
   logic        gnt0, gnt1;

   logic        ss_n_nx, mosi_nx, busy_nx;
   logic        ready0_nx, ready1_nx;
   logic        rsp_valid_nx, rsp_id_nx;
   logic [7:0]  rsp_data_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         frame      <= 10'd0;
         cap        <= 8'd0;
         id         <= 1'b0;
         ptr        <= 1'b0;
         SS_n       <= 1'b1;
         MOSI       <= 1'b0;
         busy       <= 1'b0;
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= 8'h00;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         frame      <= frame_nx;
         cap        <= cap_nx;
         id         <= id_nx;
         ptr        <= ptr_nx;
         SS_n       <= ss_n_nx;
         MOSI       <= mosi_nx;
         busy       <= busy_nx;
         req0_ready <= ready0_nx;
         req1_ready <= ready1_nx;
         rsp_valid  <= rsp_valid_nx;
         rsp_id     <= rsp_id_nx;
         rsp_data   <= rsp_data_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      frame_nx = frame;
      cap_nx   = cap;
      id_nx    = id;
      ptr_nx   = ptr;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      case (state)
         IDLE: begin
            // ptr names the requester that wins when both are valid
            gnt0 = req0_valid & (~req1_valid | ~ptr);
            gnt1 = req1_valid & (~req0_valid | ptr);
            if (gnt0 || gnt1) begin
               state_nx = SEL;
               id_nx    = gnt1;
               frame_nx = gnt1 ? {req1_op, req1_data} : {req0_op, req0_data};
               ptr_nx   = gnt0;
            end
         end
         SEL:  state_nx = CMD;
         CMD: begin
            state_nx = SHIFT;
            cnt_nx   = 4'd9;
         end
         SHIFT: begin
            if (cnt == 4'd0) state_nx = END;
            else             cnt_nx   = cnt - 4'd1;
         end
         END: begin
            if (frame[9:8] == 2'b11) begin
               state_nx = TURN;
               cnt_nx   = 4'(RD_TURN - 1);
            end else begin
               state_nx = DONE;
            end
         end
         TURN: begin
            if (cnt == 4'd0) begin
               state_nx = RDCAP;
               cnt_nx   = 4'd7;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         RDCAP: begin
            cap_nx = {cap[6:0], MISO};
            if (cnt == 4'd0) state_nx = DONE;
            else             cnt_nx   = cnt - 4'd1;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output values are decoded from the upcoming state so the flops show them during that state
   always_comb begin
      ss_n_nx      = (state_nx == IDLE) || (state_nx == DONE);
      busy_nx      = (state_nx != IDLE);
      mosi_nx      = 1'b0;
      ready0_nx    = gnt0;
      ready1_nx    = gnt1;
      rsp_valid_nx = (state == RDCAP) && (state_nx == DONE);
      rsp_id_nx    = rsp_id;
      rsp_data_nx  = rsp_data;
      if (state_nx == CMD)   mosi_nx = frame_nx[9];
      if (state_nx == SHIFT) mosi_nx = frame_nx[cnt_nx];
      if (rsp_valid_nx) begin
         rsp_id_nx   = id;
         rsp_data_nx = cap_nx;
      end
   end

endmodule

// File: tb/tb_spi_master_sched.sv
// Directed bench for spi_master_sched: reset, write frame, read frame, round-robin,
// single-requester streaming and asynchronous abort with re-grant.
module tb_spi_master_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req1_valid;
   logic [1:0] req0_op, req1_op;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic       rsp_valid, rsp_id;
   logic [7:0] rsp_data;
   logic       SS_n, MOSI, MISO, busy;

   int tests = 0;
   int fails = 0;
   logic [0:0] exp_q[$];

   spi_master_sched #(.RD_TURN(2)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Counts SS_n-high cycles until the next frame starts; returns positioned in the SEL cycle
   task automatic wait_grant(output int highs);
      highs = 0;
      while (SS_n === 1'b1 && highs < 20) begin
         highs++;
         step();
      end
      check("grant_seen", {31'd0, SS_n}, 32'd0);
   endtask

   // Walks one frame from SEL; returns positioned in the DONE cycle
   task automatic frame(input logic [7:0] miso_byte, output int low,
                        output logic [10:0] mosi, output logic rsp_early);
      low = 0;
      mosi = '0;
      rsp_early = 1'b0;
      while (SS_n === 1'b0 && low < 40) begin
         low++;
         if (low >= 2 && low <= 12) mosi[12-low] = MOSI;
         if (low >= 16 && low <= 23) MISO = miso_byte[23-low];
         if (rsp_valid === 1'b1) rsp_early = 1'b1;
         if (low == 2) check("ready_one_cycle", {30'd0, req0_ready, req1_ready}, 32'd0);
         step();
      end
      MISO = 1'b0;
      check("frame_bounded", {31'd0, low < 40}, 32'd1);
   endtask

   int         h, low;
   logic [10:0] mosi;
   logic       early;

   initial begin
      // reset with both requesters valid
      rst = 1'b1; MISO = 1'b0;
      req0_valid = 1'b1; req0_op = 2'b00; req0_data = 8'hA5;
      req1_valid = 1'b1; req1_op = 2'b11; req1_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ss_n", {31'd0, SS_n}, 32'd1);
      check("rst_mosi", {31'd0, MOSI}, 32'd0);
      check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
      check("rst_rsp_data", {24'd0, rsp_data}, 32'h00);
      check("rst_busy", {31'd0, busy}, 32'd0);

      // write-address 0xA5 from req0, granted on the first edge after release
      req1_valid = 1'b0;
      rst = 1'b0;
      step();
      check("wa_ready", {30'd0, req0_ready, req1_ready}, 32'b10);
      check("wa_sel_ss_n", {31'd0, SS_n}, 32'd0);
      check("wa_sel_mosi", {31'd0, MOSI}, 32'd0);
      check("wa_busy", {31'd0, busy}, 32'd1);
      req0_valid = 1'b0;
      frame(8'h00, low, mosi, early);
      check("wa_ss_low", low, 13);
      check("wa_mosi", {21'd0, mosi}, {21'd0, 11'b000_1010_0101});
      check("wa_no_rsp_in_frame", {31'd0, early}, 32'd0);
      check("wa_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("wa_done_busy", {31'd0, busy}, 32'd1);
      step();
      check("wa_idle_busy", {31'd0, busy}, 32'd0);
      check("wa_idle_ss_n", {31'd0, SS_n}, 32'd1);

      // read-data from req1, MISO returns 0x3C
      req1_valid = 1'b1; req1_op = 2'b11; req1_data = 8'h5A;
      wait_grant(h);
      check("rd_ready", {30'd0, req0_ready, req1_ready}, 32'b01);
      req1_valid = 1'b0;
      frame(8'h3C, low, mosi, early);
      check("rd_ss_low", low, 23);
      check("rd_mosi", {21'd0, mosi}, {21'd0, 1'b1, 2'b11, 8'h5A});
      check("rd_no_early_rsp", {31'd0, early}, 32'd0);
      check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("rd_rsp_data", {24'd0, rsp_data}, 32'h3C);
      check("rd_rsp_id", {31'd0, rsp_id}, 32'd1);
      step();
      check("rd_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
      check("rd_rsp_hold", {24'd0, rsp_data}, 32'h3C);

      // both valid continuously from reset: grants alternate 0,1,0,1
      rst = 1'b1;
      req0_valid = 1'b1; req0_op = 2'b01; req0_data = 8'h11;
      req1_valid = 1'b1; req1_op = 2'b10; req1_data = 8'h22;
      step();
      check("rr_rst_clears_rsp", {24'd0, rsp_data}, 32'h00);
      rst = 1'b0;
      for (int g = 0; g < 4; g++) exp_q.push_back(1'(g % 2));
      for (int g = 0; g < 4; g++) begin
         logic [0:0] exp_id;
         wait_grant(h);
         exp_id = exp_q.pop_front();
         if (g > 0) check("rr_gap", h, 2);
         check("rr_grant", {30'd0, req0_ready, req1_ready}, (exp_id == 1'b0) ? 32'b10 : 32'b01);
         frame(8'h00, low, mosi, early);
         check("rr_ss_low", low, 13);
      end

      // only req1 valid: it wins every frame regardless of pointer
      req0_valid = 1'b0;
      req1_op = 2'b00; req1_data = 8'h0F;
      for (int g = 0; g < 3; g++) begin
         wait_grant(h);
         check("solo_gap", h, 2);
         check("solo_grant", {30'd0, req0_ready, req1_ready}, 32'b01);
         frame(8'h00, low, mosi, early);
         check("solo_ss_low", low, 13);
      end

      // reset during SHIFT bit 4 of a read-data frame, then re-grant
      req1_op = 2'b11; req1_data = 8'h5B;
      wait_grant(h);
      check("abort_grant", {30'd0, req0_ready, req1_ready}, 32'b01);
      repeat (7) step();
      check("abort_bit4_mosi", {31'd0, MOSI}, 32'd1);
      check("abort_bit4_ss_n", {31'd0, SS_n}, 32'd0);
      #2 rst = 1'b1;
      #1;
      check("abort_ss_n_async", {31'd0, SS_n}, 32'd1);
      check("abort_mosi", {31'd0, MOSI}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check("abort_rsp_data", {24'd0, rsp_data}, 32'h00);
      step();
      rst = 1'b0;
      wait_grant(h);
      check("regrant", {30'd0, req0_ready, req1_ready}, 32'b01);
      req1_valid = 1'b0;
      frame(8'hE1, low, mosi, early);
      check("regrant_ss_low", low, 23);
      check("regrant_mosi", {21'd0, mosi}, {21'd0, 1'b1, 2'b11, 8'h5B});
      check("regrant_no_early", {31'd0, early}, 32'd0);
      check("regrant_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("regrant_rsp_data", {24'd0, rsp_data}, 32'hE1);
      check("regrant_rsp_id", {31'd0, rsp_id}, 32'd1);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
